// File: rtl/column_stream_packer.sv
// column_stream_packer: buffers K-pixel columns in a FIFO and serializes them into LANES-pixel
// ready/valid beats, keeping column, drop and pixel-checksum statistics.
module column_stream_packer #(
   parameter int K           = 3,
   parameter int PIXEL_WIDTH = 8,
   parameter int LANES       = 1,
   parameter int FIFO_DEPTH  = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [K*PIXEL_WIDTH-1:0]     in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES*PIXEL_WIDTH-1:0] out_data,
   output logic                         out_col_end,
   output logic                         out_frame_end,
   output logic                         overflow,
   output logic [CNT_WIDTH-1:0]         col_count,
   output logic [CNT_WIDTH-1:0]         drop_count,
   output logic [CNT_WIDTH-1:0]         checksum
);
   localparam int BEATS = K / LANES;
   localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = LANES * PIXEL_WIDTH;

   typedef enum logic {EMPTY, SEND} state_t;

   state_t                    state_q, state_d;
   logic [AW:0]               wr_q, rd_q;
   logic [K*PIXEL_WIDTH:0]    mem_q [FIFO_DEPTH];
   logic [BEATS-1:0][LW-1:0]  stage_q, stage_d;
   logic                      last_q, last_d;
   logic [BW-1:0]             beat_q, beat_d;
   logic [CNT_WIDTH-1:0]      col_q, drop_q, sum_q, pix_sum;
   logic                      ovf_q, empty, full, last_beat, hs, pop, push;

   // pointers carry a wrap bit so full and empty are distinguishable at equal addresses
   assign empty     = wr_q == rd_q;
   assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign last_beat = beat_q == BW'(BEATS - 1);
   assign hs        = (state_q == SEND) && out_ready;
   assign pop       = !empty && ((state_q == EMPTY) || (hs && last_beat));
   assign push      = in_valid && (!full || pop);

   always_comb begin
      pix_sum = '0;
      for (int i = 0; i < K; i++) pix_sum += CNT_WIDTH'(in_data[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      stage_d = stage_q;
      last_d  = last_q;
      if (pop) begin
         state_d           = SEND;
         beat_d            = '0;
         {last_d, stage_d} = mem_q[rd_q[AW-1:0]];
      end else if (hs) begin
         state_d = last_beat ? EMPTY : SEND;
         beat_d  = last_beat ? beat_q : beat_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         wr_q    <= '0;
         rd_q    <= '0;
         stage_q <= '0;
         last_q  <= 1'b0;
         beat_q  <= '0;
         col_q   <= '0;
         drop_q  <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         if (pop) rd_q <= rd_q + 1'b1;
         if (push) begin
            wr_q  <= wr_q + 1'b1;
            col_q <= col_q + 1'b1;
            sum_q <= sum_q + pix_sum;
         end else if (in_valid) begin
            drop_q <= drop_q + 1'b1;
            ovf_q  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) if (push) mem_q[wr_q[AW-1:0]] <= {in_last, in_data};

   assign out_valid     = state_q == SEND;
   assign out_data      = stage_q[beat_q];
   assign out_col_end   = out_valid && last_beat;
   assign out_frame_end = out_col_end && last_q;
   assign overflow      = ovf_q;
   assign col_count     = col_q;
   assign drop_count    = drop_q;
   assign checksum      = sum_q;
endmodule

// File: tb/tb_column_stream_packer.sv
// tb_column_stream_packer: runs a K=3/LANES=1 and a K=4/LANES=2 packer in lockstep against a
// transaction-level model of the column queue, output stage and statistics.
module tb_column_stream_packer;
   localparam int D = 4;

   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [31:0] din = '0;

   logic        a_out_valid, a_col_end, a_frame_end, a_overflow;
   logic [7:0]  a_out_data;
   logic [31:0] a_col_count, a_drop_count, a_checksum;
   logic        b_out_valid, b_col_end, b_frame_end, b_overflow;
   logic [15:0] b_out_data;
   logic [31:0] b_col_count, b_drop_count, b_checksum;

   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   column_stream_packer #(.K(3), .PIXEL_WIDTH(8), .LANES(1), .FIFO_DEPTH(D), .CNT_WIDTH(32)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(din[23:0]), .in_last(in_last),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .out_col_end(a_col_end), .out_frame_end(a_frame_end), .overflow(a_overflow),
      .col_count(a_col_count), .drop_count(a_drop_count), .checksum(a_checksum));

   column_stream_packer #(.K(4), .PIXEL_WIDTH(8), .LANES(2), .FIFO_DEPTH(D), .CNT_WIDTH(32)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(din), .in_last(in_last),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .out_col_end(b_col_end), .out_frame_end(b_frame_end), .overflow(b_overflow),
      .col_count(b_col_count), .drop_count(b_drop_count), .checksum(b_checksum));

   typedef struct packed {logic l; logic [31:0] d;} col_t;

   // reference: pending columns as a ring of records, plus the column being sent and its beat
   col_t        fm [2][64];
   int          hd [2], tl [2], bi [2];
   bit          sv [2], ov [2];
   col_t        stg [2];
   logic [31:0] cc [2], dc [2], cs [2];

   task automatic chk(input string tag, input int u, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s[%0d]: got %h expected %h", tag, u, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         hd[u] = 0; tl[u] = 0; bi[u] = 0; sv[u] = 0; ov[u] = 0;
         cc[u] = '0; dc[u] = '0; cs[u] = '0; stg[u] = '0;
      end
   endtask

   task automatic check_all();
      for (int u = 0; u < 2; u++) begin
         int          lw;
         logic [31:0] mask, dd;
         logic        lb;
         lw   = (u == 1) ? 16 : 8;
         mask = (32'h1 << lw) - 32'h1;
         dd   = (u == 1) ? 32'(b_out_data) : 32'(a_out_data);
         lb   = bi[u] == ((u == 1) ? 1 : 2);
         chk("out_valid", u, 32'((u == 1) ? b_out_valid : a_out_valid), 32'(sv[u]));
         if (sv[u]) chk("out_data", u, dd, (stg[u].d >> (bi[u] * lw)) & mask);
         chk("out_col_end", u, 32'((u == 1) ? b_col_end : a_col_end), 32'(sv[u] && lb));
         chk("out_frame_end", u, 32'((u == 1) ? b_frame_end : a_frame_end), 32'(sv[u] && lb && stg[u].l));
         chk("col_count", u, (u == 1) ? b_col_count : a_col_count, cc[u]);
         chk("drop_count", u, (u == 1) ? b_drop_count : a_drop_count, dc[u]);
         chk("checksum", u, (u == 1) ? b_checksum : a_checksum, cs[u]);
         chk("overflow", u, 32'((u == 1) ? b_overflow : a_overflow), 32'(ov[u]));
      end
   endtask

   task automatic model_step(input bit v, input logic [31:0] d, input bit l, input bit r);
      for (int u = 0; u < 2; u++) begin
         int          k, beats, n;
         bit          h, lb, pop, acc;
         logic [31:0] dm;
         k     = (u == 1) ? 4 : 3;
         beats = (u == 1) ? 2 : 3;
         dm    = (u == 1) ? d : (d & 32'h00ff_ffff);
         h     = sv[u] && r;
         lb    = bi[u] == beats - 1;
         n     = tl[u] - hd[u];
         pop   = n > 0 && (!sv[u] || (h && lb));
         acc   = v && (n < D || pop);
         if (h && !lb) bi[u]++;
         if (pop) begin
            stg[u] = fm[u][hd[u] % 64];
            hd[u]++;
            bi[u] = 0;
            sv[u] = 1;
         end else if (h && lb) sv[u] = 0;
         if (acc) begin
            fm[u][tl[u] % 64] = '{l: l, d: dm};
            tl[u]++;
            cc[u]++;
            for (int i = 0; i < k; i++) cs[u] += (dm >> (8 * i)) & 32'hff;
         end else if (v) begin
            dc[u]++;
            ov[u] = 1;
         end
      end
   endtask

   task automatic step(input bit v, input logic [31:0] d, input bit l, input bit r);
      in_valid  = v;
      din       = d;
      in_last   = l;
      out_ready = r;
      check_all();
      model_step(v, d, l, r);
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", 0, 32'(a_out_data), 32'h0);
      chk("rst_data", 1, 32'(b_out_data), 32'h0);
      rst = 1'b0;
      check_all();

      // single column: beats 01,02,03 on the narrow instance
      step(1, 32'h0403_0201, 0, 1);
      repeat (5) step(0, 32'h0, 0, 1);
      chk("serial_cksum", 0, a_checksum, 32'd6);
      chk("serial_cnt", 0, a_col_count, 32'd1);
      chk("serial_cksum", 1, b_checksum, 32'd10);

      // back-to-back columns under toggling backpressure
      for (int i = 0; i < 4; i++) step(1, $urandom, 0, i[0] == 1'b0);
      for (int i = 0; i < 30; i++) step(0, 32'h0, 0, i[0] == 1'b0);

      // overflow: stage + 4 FIFO entries, two drops
      for (int i = 0; i < 7; i++) step(1, $urandom, 0, 0);
      chk("ovf_drops", 0, a_drop_count, 32'd2);
      chk("ovf_drops", 1, b_drop_count, 32'd2);
      chk("ovf_flag", 0, 32'(a_overflow), 32'd1);
      chk("ovf_cols", 0, a_col_count, 32'd10);
      repeat (40) step(0, 32'h0, 0, 1);

      // full FIFO accepts a column when the last beat pops in the same cycle
      repeat (5) step(1, $urandom, 0, 0);
      step(0, 32'h0, 0, 1);
      step(0, 32'h0, 0, 1);
      step(1, $urandom, 0, 1);
      chk("simul_pop_drops", 0, a_drop_count, 32'd2);
      chk("simul_pop_drops", 1, b_drop_count, 32'd2);
      repeat (40) step(0, 32'h0, 0, 1);

      // frame end on the second column
      step(1, $urandom, 0, 1);
      step(1, $urandom, 1, 1);
      repeat (12) step(0, 32'h0, 0, 1);

      for (int i = 0; i < 300; i++)
         step($urandom_range(3, 0) != 0, $urandom, $urandom_range(4, 0) == 0, $urandom_range(2, 0) != 0);
      repeat (40) step(0, 32'h0, 0, 1);

      // asynchronous reset in the middle of a column
      step(1, $urandom, 0, 0);
      step(1, $urandom, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 0, 32'(a_out_valid), 32'h0);
      chk("arst_valid", 1, 32'(b_out_valid), 32'h0);
      chk("arst_data", 0, 32'(a_out_data), 32'h0);
      chk("arst_cols", 0, a_col_count, 32'h0);
      chk("arst_drops", 1, b_drop_count, 32'h0);
      chk("arst_cksum", 0, a_checksum, 32'h0);
      chk("arst_ovf", 1, 32'(b_overflow), 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      step(1, 32'h0000_0A0B, 0, 1);
      chk("lat_edge1", 0, 32'(a_out_valid), 32'h0);
      step(0, 32'h0, 0, 1);
      chk("lat_edge2", 0, 32'(a_out_valid), 32'h1);
      repeat (6) step(0, 32'h0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/column_stream_packer.md
# column_stream_packer

Synthesizable successor to the capture side of the row-buffer simulation flow. It accepts one K-pixel window column per cycle from the row-buffer datapath and buffers it in a small FIFO, so it can accept columns without backpressuring the datapath. It serializes each column into LANES-pixel beats on a ready/valid stream and keeps running column-count, drop-count and checksum statistics. It sits between `top`'s column output and any narrower consumer (DMA, UART bridge, on-chip checker), replacing file-based capture.

## Interface
- K, 3, pixels per column (window height)
- PIXEL_WIDTH, 8, bits per pixel
- LANES, 1, pixels per output beat; must divide K
- FIFO_DEPTH, 16, column entries; power of 2, ≥2
- CNT_WIDTH, 32, width of statistics counters

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  column present this cycle
- in_data  in  K*PIXEL_WIDTH  pixel i at [(i+1)*PIXEL_WIDTH-1 -: PIXEL_WIDTH]
- in_last  in  1  column is the last of a frame
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  LANES*PIXEL_WIDTH  lane j = pixel (beat*LANES+j)
- out_col_end  out  1  last beat of a column
- out_frame_end  out  1  last beat of a column tagged in_last
- overflow  out  1  sticky: at least one column dropped
- col_count  out  CNT_WIDTH  columns accepted, wraps
- drop_count  out  CNT_WIDTH  columns dropped, wraps
- checksum  out  CNT_WIDTH  sum of all accepted pixels, mod 2^CNT_WIDTH

## Operation
- Storage: FIFO of FIFO_DEPTH entries {in_last, in_data}, plus one output-stage column register with beat index b in 0..BEATS-1, where BEATS = K/LANES.
- States:
  - EMPTY: stage unloaded, out_valid=0.
  - SEND: stage loaded, out_valid=1.
- Transitions:
  - EMPTY→SEND: FIFO non-empty. Pop the head into the stage and set b=0.
  - In SEND, on out_valid&&out_ready:
    - b<BEATS-1: increment b.
    - b=BEATS-1 and FIFO non-empty: reload the stage in the same cycle with b=0. No bubble.
    - b=BEATS-1 and FIFO empty: go to EMPTY.
- A FIFO entry is freed on the cycle it loads into the stage.
- Push: in_valid accepted when FIFO not full, or when full and a pop happens the same cycle.
  - On accept: col_count+1; checksum += sum of the K pixels, computed at CNT_WIDTH width, wrapping.
  - Otherwise the column is dropped: drop_count+1 and overflow←1. Column contents are not stored or summed.
- Push into an empty FIFO while in EMPTY: the column is written, then popped on the next edge. There is no write-through bypass.
- out_col_end = (b==BEATS-1) while in SEND.
- out_frame_end = out_col_end && the stage's stored last bit.
- out_data, out_col_end and out_frame_end hold stable while out_valid && !out_ready.
- overflow clears only on rst.

## Timing
- rst asserted: every output is 0 and state is EMPTY, immediately and asynchronously; FIFO pointers are cleared. Any column mid-serialization is discarded.
- Column accepted at edge N into an empty block: it loads the stage at edge N+1, so out_valid=1 after edge N+1. Latency is 2 edges.
- Throughput: one column per BEATS cycles with out_ready held high. With LANES=K, one column per cycle with no drops.
- Statistics registers update at the edge that accepts or drops the column, and are visible the following cycle.
- FIFO full is defined as occupancy = FIFO_DEPTH. Pointers carry one extra wrap bit.

## Test plan
- Reset: assert rst mid-SEND with K=3, LANES=1 → out_valid, counters and overflow all 0 asynchronously; the first column after release reappears with 2-edge latency.
- Serialize: K=3, LANES=1, in_data=0x030201, out_ready=1 → beats 0x01, 0x02, 0x03 on consecutive cycles; out_col_end only on 0x03; checksum=6; col_count=1.
- Back-to-back with backpressure: 4 columns, out_ready toggling 1/0 → every beat delivered in order; no bubble between columns when ready; data stable while stalled.
- Overflow: FIFO_DEPTH=4, out_ready=0, 7 consecutive columns → stage holds 1 and FIFO holds 4; drop_count=2, overflow=1, col_count=5. After out_ready=1, the 5 accepted columns drain in order.
- Full with simultaneous pop: FIFO full, last beat handshaken in the same cycle as in_valid → column accepted, drop_count unchanged.
- Frame end and wide lanes: K=4, LANES=2, in_last=1 on the 2nd column → out_frame_end only on beat 2 of column 2; checksum matches the software sum mod 2^32.
